// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider. It produces one quotient bit per clock, MSB
//   first. Each step is a trial subtraction done as an add of ~B with carry-in
//   1. A carry-out of 1 means the trial result is non-negative, so it is kept.
//
//   Optional macro: SEQ_DIVIDER_SIGNED_EN
//     Undefined : unsigned division only.
//     Defined   : two's complement operands. The block divides the
//                 magnitudes. In the final register stage it negates the
//                 quotient when the operand signs differ, and negates the
//                 remainder when A < 0. This truncates toward zero.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request a division; accepted whenever busy is low
//   A, B         : dividend / divisor, captured on the accept edge
//   Quotient     : quotient result, held until the next accepted start
//   Remainder    : remainder result, held until the next accepted start
//   busy         : high while iterating (WIDTH cycles)
//   done         : one-cycle pulse when Quotient/Remainder become valid
//   div_by_zero  : set together with done when the captured B was zero
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;        // dividend bits; quotient bits shift in at the LSB
    logic [WIDTH-1:0] b_q;        // divisor (magnitude in signed mode)
    // After each step the kept remainder is < B, so its top bit is always
    // zero. The full WIDTH+1 bit working value exists only as shift_d/sum_d.
    logic [WIDTH-1:0] part_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH:0]   shift_d;
    logic [WIDTH+1:0] sum_d;
    logic             qbit_d;
    logic [WIDTH:0]   part_d;
    logic [WIDTH-1:0] quo_raw_d, rem_raw_d;
    logic [WIDTH-1:0] quo_fix_d, rem_fix_d;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic             last_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_q, neg_r_q;
`endif

    // One restoring step: shift in the next dividend bit, then trial-subtract
    // the divisor through the adder path (~B + 1).
    always_comb begin
        shift_d   = {part_q, a_q[WIDTH-1]};
        sum_d     = {1'b0, shift_d} + {1'b0, ~{1'b0, b_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
        qbit_d    = sum_d[WIDTH+1];
        part_d    = qbit_d ? sum_d[WIDTH:0] : shift_d;
        quo_raw_d = {a_q[WIDTH-2:0], qbit_d};
        rem_raw_d = part_d[WIDTH-1:0];
        last_d    = (cnt_q == CW'(WIDTH-1));
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    // For the most-negative operand the "magnitude" is the same bit pattern.
    // Read as unsigned, that pattern is the correct magnitude, so
    // MIN / -1 wraps back to MIN.
    always_comb begin
        mag_a_d   = A[WIDTH-1] ? (~A + 1'b1) : A;
        mag_b_d   = B[WIDTH-1] ? (~B + 1'b1) : B;
        quo_fix_d = neg_q_q ? (~quo_raw_d + 1'b1) : quo_raw_d;
        rem_fix_d = neg_r_q ? (~rem_raw_d + 1'b1) : rem_raw_d;
    end
`else
    always_comb begin
        mag_a_d   = A;
        mag_b_d   = B;
        quo_fix_d = quo_raw_d;
        rem_fix_d = rem_raw_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q    <= mag_a_d;
                        b_q    <= mag_b_d;
                        part_q <= '0;
                        cnt_q  <= '0;
                        dbz_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r_q <= A[WIDTH-1];
`endif
                        if (B != '0) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end else begin
                            // Zero divisor: skip iteration, report immediately.
                            state_q <= DONE;
                            quo_q   <= '1;
                            rem_q   <= A;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q    <= quo_raw_d;
                    part_q <= rem_raw_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_d) begin
                        state_q <= DONE;
                        quo_q   <= quo_fix_d;
                        rem_q   <= rem_fix_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Quotient    = quo_q;
    assign Remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Table-driven directed vectors for seq_divider (WIDTH=4), followed by
//   hand-written sequences. These cover back-to-back starts, a start issued
//   while busy, and a reset during iteration. Inputs change on the falling
//   edge, and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Quotient, Remainder;
    logic         busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .Quotient(Quotient), .Remainder(Remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] a, b, q, r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    // Independent reference using the language's own / and % operators.
    task automatic ref_div(input logic [W-1:0] a, b, output logic [W-1:0] q, r);
`ifdef SEQ_DIVIDER_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == '0) begin q = '1; r = a; end
        else begin q = W'(sa / sb); r = W'(sa % sb); end
`else
        if (b == '0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
`endif
    endtask

    // Wait on falling edges until done is seen; the count is bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc, pulses;
        logic [W-1:0] eq, er, seen_q, seen_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
        add_vec(4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0); // -7 / 2
        add_vec(4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0); // -8 / -1 wraps
        add_vec(4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0); // 7 / -2
        add_vec(4'b1001, 4'b1110, 4'd3,    4'b1111, 1'b0); // -7 / -2
        add_vec(4'b1111, 4'd4,    4'd0,    4'b1111, 1'b0); // -1 / 4
        add_vec(4'd7,    4'd3,    4'd2,    4'd1,    1'b0);
        add_vec(4'd5,    4'd0,    4'b1111, 4'd5,    1'b1);
        add_vec(4'b1000, 4'd0,    4'b1111, 4'b1000, 1'b1);
`else
        add_vec(4'd13, 4'd3,  4'd4,  4'd1,  1'b0);
        add_vec(4'd7,  4'd0,  4'd15, 4'd7,  1'b1);
        add_vec(4'd15, 4'd1,  4'd15, 4'd0,  1'b0);
        add_vec(4'd2,  4'd5,  4'd0,  4'd2,  1'b0);
        add_vec(4'd0,  4'd7,  4'd0,  4'd0,  1'b0);
        add_vec(4'd15, 4'd15, 4'd1,  4'd0,  1'b0);
        add_vec(4'd14, 4'd4,  4'd3,  4'd2,  1'b0);
        add_vec(4'd1,  4'd15, 4'd0,  4'd1,  1'b0);
        add_vec(4'd12, 4'd0,  4'd15, 4'd12, 1'b1);
`endif

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_quotient", 32'(Quotient), 0);
        chk("rst_remainder", 32'(Remainder), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            A = vecs[i].a; B = vecs[i].b; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (vecs[i].b != '0) chk($sformatf("v%0d_busy", i), 32'(busy), 1);
            wait_done(cyc);
            chk($sformatf("v%0d_latency", i), cyc, (vecs[i].b == '0) ? 0 : W);
            chk($sformatf("v%0d_quotient", i), 32'(Quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_remainder", i), 32'(Remainder), 32'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            chk($sformatf("v%0d_hold_q", i), 32'(Quotient), 32'(vecs[i].q));
        end

        // Back-to-back: the second start is accepted directly from DONE.
        @(negedge clk);
        A = 4'd15; B = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        ref_div(4'd15, 4'd1, eq, er);
        chk("b2b1_latency", cyc, W);
        chk("b2b1_quotient", 32'(Quotient), 32'(eq));
        chk("b2b1_remainder", 32'(Remainder), 32'(er));
        A = 4'd2; B = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b2_no_idle_busy", 32'(busy), 1);
        chk("b2b2_done_low", 32'(done), 0);
        wait_done(cyc);
        ref_div(4'd2, 4'd5, eq, er);
        chk("b2b2_latency", cyc, W);
        chk("b2b2_quotient", 32'(Quotient), 32'(eq));
        chk("b2b2_remainder", 32'(Remainder), 32'(er));

        // A start while busy is ignored.
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd9; B = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; seen_q = '0; seen_r = '0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) begin
                pulses++;
                seen_q = Quotient;
                seen_r = Remainder;
            end
            @(negedge clk);
        end
        ref_div(4'd13, 4'd3, eq, er);
        chk("ign_pulses", pulses, 1);
        chk("ign_quotient", 32'(seen_q), 32'(eq));
        chk("ign_remainder", 32'(seen_r), 32'(er));
        chk("ign_hold_q", 32'(Quotient), 32'(eq));

        // Reset during CALC aborts; no done afterwards.
        @(negedge clk);
        A = 4'd13; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_quotient", 32'(Quotient), 0);
        chk("midrst_remainder", 32'(Remainder), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        chk("midrst_idle_busy", 32'(busy), 0);
        A = 4'd6; B = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("post_rst_latency", cyc, W);
        chk("post_rst_quotient", 32'(Quotient), 1);
        chk("post_rst_remainder", 32'(Remainder), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
